// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory/writeback stage: RV32I LOAD/STORE funct3
// encodings, the stage state type and the access-legality check.
package mem_stage_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    MEMST_IDLE = 1'b0,
    MEMST_BUSY = 1'b1
  } memst_t;

  // Width/alignment legality; unsigned widths exist only for loads.
  function automatic logic access_legal(input logic ren, input logic wen,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (!(ren && wen)) begin
      case (funct3)
        FUNCT3_LB:  ok = 1'b1;
        FUNCT3_LH:  ok = !addr_lo[0];
        FUNCT3_LW:  ok = (addr_lo == 2'b00);
        FUNCT3_LBU: ok = ren;
        FUNCT3_LHU: ok = ren && !addr_lo[0];
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension of a 32-bit bus read word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      FUNCT3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      FUNCT3_LBU: o_data = {24'h0, w_byte};
      FUNCT3_LH:  o_data = {{16{w_half[15]}}, w_half};
      FUNCT3_LHU: o_data = {16'h0, w_half};
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access/writeback stage: ALU results go straight to writeback, loads
// and stores run a req/ack bus transaction while stalling execute.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_reg_addr,
  input  logic [31:0] ex_reg_data,
  input  logic [31:0] ex_mem_addr,
  input  logic        ex_mem_ren,
  input  logic        ex_mem_wen,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_store_data,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        err
);

  memst_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_rd;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_cnt;
  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_err;

  logic        w_legal;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load;

  assign w_legal = access_legal(ex_mem_ren, ex_mem_wen, ex_funct3, ex_mem_addr[1:0]);

  // Store data replicated into every lane; the strobe picks the live one.
  always_comb begin
    w_wdata = ex_store_data;
    w_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        w_wdata = {4{ex_store_data[7:0]}};
        w_wstrb = 4'b0001 << ex_mem_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{ex_store_data[15:0]}};
        w_wstrb = 4'b0011 << ex_mem_addr[1:0];
      end
      default: begin
        w_wdata = ex_store_data;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_addr   (r_addr_lo),
    .i_funct3 (r_funct3),
    .o_data   (w_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MEMST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      r_cnt     <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        MEMST_IDLE: begin
          if (ex_valid) begin
            if (!ex_mem_ren && !ex_mem_wen) begin
              r_wb_en   <= (ex_reg_addr != 5'd0);
              r_wb_addr <= ex_reg_addr;
              r_wb_data <= ex_reg_data;
            end else if (w_legal) begin
              r_state   <= MEMST_BUSY;
              r_req     <= 1'b1;
              r_we      <= ex_mem_wen;
              r_addr    <= {ex_mem_addr[31:2], 2'b00};
              r_wdata   <= ex_mem_wen ? w_wdata : '0;
              r_wstrb   <= ex_mem_wen ? w_wstrb : '0;
              r_rd      <= ex_reg_addr;
              r_funct3  <= ex_funct3;
              r_addr_lo <= ex_mem_addr[1:0];
              r_cnt     <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        MEMST_BUSY: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (dmem_ack) begin
            r_state <= MEMST_IDLE;
            r_req   <= 1'b0;
            if (!r_we) begin
              r_wb_en   <= (r_rd != 5'd0);
              r_wb_addr <= r_rd;
              r_wb_data <= w_load;
            end
          end else if (TIMEOUT != 0 && r_cnt == TIMEOUT - 1) begin
            r_state <= MEMST_IDLE;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= MEMST_IDLE;
      endcase
    end
  end

  assign stall      = (r_state == MEMST_BUSY);
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_wstrb = r_wstrb;
  assign wb_en      = r_wb_en;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign err        = r_err;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access/writeback stage that consumes the execute stage's result bundle (`reg_addr`/`reg_data`, `mem_addr`, `mem_ren`/`mem_wen`) and completes it. ALU results pass straight to the register-file write port. Loads and stores run a req/ack transaction on the data-memory bus, with byte-lane steering, sign/zero extension and misalignment checks. While a memory transaction is in flight it back-pressures execute with `stall`.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles `dmem_req` waits for `dmem_ack` before abort; 0 disables the timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: ex_* bundle holds a new op this cycle.
- `ex_reg_addr` in 5: destination register (rd).
- `ex_reg_data` in 32: ALU result (non-memory ops).
- `ex_mem_addr` in 32: byte address for load/store.
- `ex_mem_ren` in 1: op is a load.
- `ex_mem_wen` in 1: op is a store.
- `ex_funct3` in 3: access width/sign (RV32I LOAD/STORE encoding).
- `ex_store_data` in 32: store source (rs2), LSB-aligned.
- `stall` out 1: stage busy; ex_* is neither consumed nor allowed to change.
- `dmem_req` out 1: bus request, held until ack or abort.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{ex_mem_addr[31:2], 2'b00}`.
- `dmem_wdata` out 32: store data replicated into lanes.
- `dmem_wstrb` out 4: byte enables.
- `dmem_rdata` in 32: read data, valid with ack.
- `dmem_ack` in 1: transaction complete.
- `wb_en` out 1: register write strobe.
- `wb_addr` out 5: register index.
- `wb_data` out 32: register value.
- `err` out 1: one-cycle pulse on misaligned/illegal access or timeout.

## Operation
- States: IDLE, BUSY.
- `stall` = (state == BUSY).
- IDLE, `ex_valid`, neither ren nor wen: next cycle `wb_en` = (`ex_reg_addr` != 0), `wb_addr` = rd, `wb_data` = `ex_reg_data`. State stays IDLE.
- IDLE, `ex_valid`, ren xor wen, access legal: latch the bundle. Next cycle `dmem_req`=1, `dmem_we`=wen, state BUSY.
- Legal width/alignment:
  - funct3 000 (LB/SB) and 100 (LBU): any address.
  - 001 (LH/SH) and 101 (LHU): `addr[0]`=0.
  - 010 (LW/SW): `addr[1:0]`=0.
  - Any other funct3, or ren and wen both set, is illegal; 100/101 are illegal for stores.
- Illegal access: no bus request, no writeback. `err` pulses next cycle; state stays IDLE.
- Store lanes:
  - SB: wdata = byte ×4, wstrb = `0001 << addr[1:0]`.
  - SH: wdata = half ×2, wstrb = `0011 << addr[1:0]`.
  - SW: wstrb = `1111`.
- Load data: select the lane by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend.
- BUSY, `dmem_ack` sampled high:
  - `dmem_req` drops next cycle and state returns to IDLE.
  - Load: next cycle `wb_en` = (rd != 0) with `wb_data` the extended value.
  - Store: no writeback.
- BUSY timeout: a counter clears on entry and increments each BUSY cycle. When it reaches `TIMEOUT` without ack, `dmem_req` drops, `err` pulses, there is no writeback, and state returns to IDLE.
- `dmem_ack` while `dmem_req` is low is ignored.
- `wb_en` and `err` are single-cycle pulses. `wb_addr`/`wb_data` hold their last value otherwise.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-transaction drops `dmem_req` immediately (async), with no writeback and no `err`.
- ALU op: 1 cycle from accept edge to `wb_en`.
- Load: earliest path is accept edge → `dmem_req` high; ack on the first BUSY cycle → `wb_en` on the next cycle. That is 2 cycles minimum, plus 1 per wait cycle.
- Store: earliest path is accept edge → req; ack → IDLE next cycle.
- `dmem_addr`/`dmem_we`/`dmem_wdata`/`dmem_wstrb` are stable for the whole time `dmem_req` is high.
- The op execute presents while `stall` is high is accepted on the first IDLE cycle. No ops are lost or duplicated.

## Structure
- `defenitions.v` gains:
  - `FUNCT3_LB/LH/LW/LBU/LHU` and `FUNCT3_SB/SH/SW` constants.
  - `MEMST_IDLE`/`MEMST_BUSY` state encodings.
- One combinational sub-module, `load_align`: inputs rdata, `addr[1:0]`, funct3; output is the extended 32-bit value.
- The store lane/strobe logic stays inline.

## Test plan
- ALU op: rd=5, data 0x1234 → `wb_en`=1, `wb_addr`=5, `wb_data`=0x1234 next cycle, `stall` never high. Same with rd=0 → `wb_en` stays 0.
- LB at 0x1003, memory word 0x80FF_0000, ack after 3 cycles → `wb_data`=0xFFFF_FF80. LBU same → 0x0000_0080. `stall` high exactly while `dmem_req`=1.
- SH of 0xABCD at 0x2002 → `dmem_addr`=0x2000, `wdata`=0xABCD_ABCD, `wstrb`=1100, no writeback. SW at 0x2002 → `err` pulse, no `dmem_req`.
- `TIMEOUT`=4, ack never arrives → `dmem_req` high for 4 cycles, then `err` pulse, no writeback, IDLE. The next ALU op is accepted normally.
- Back-to-back: LW (ack same cycle as first req) followed by an ALU op held during stall → both writebacks occur in order, one cycle each.
- Assert `rst` while BUSY → `dmem_req`, `stall`, `wb_en` go 0 immediately. A late `dmem_ack` after reset is ignored.
